// File: rtl/mod4051_pkg.sv
// Shared constants and state encoding for the modulo-4051 chunk reducer.
// Compile-time content only.
package mod4051_pkg;

  localparam int MOD    = 4051;
  localparam int XW     = 500;
  localparam int CW     = 6;
  localparam int RW     = 12;
  localparam int NCHUNK = 84;
  localparam int IDXW   = 7;
  localparam int SW     = NCHUNK * CW;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_add_4051.sv
// Combinational modular adder with a single conditional subtract; ge_mod flags an out-of-range b.
// Zero latency, no flow control.
module mod_add_4051
  import mod4051_pkg::*;
(
  input  logic [RW-1:0] a,
  input  logic [RW-1:0] b,
  output logic [RW-1:0] sum,
  output logic          ge_mod
);

  localparam logic [RW:0] MOD_W = (RW+1)'(MOD);

  logic [RW:0] s;
  logic        wrap;

  always_comb begin
    s      = {1'b0, a} + {1'b0, b};
    wrap   = (s >= MOD_W);
    sum    = wrap ? RW'(s - MOD_W) : s[RW-1:0];
    ge_mod = ({1'b0, b} >= MOD_W);
  end

endmodule

// File: rtl/mod4051_seq_reducer.sv
// Reduces a 500-bit operand mod 4051, one 6-bit chunk per cycle: 84 RUN cycles, result from accept+85.
// One operand in flight; in_ready low until the residue is taken, out_valid held until out_ready.
module mod4051_seq_reducer
  import mod4051_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XW-1:0]   in_x,
  output logic [IDXW-1:0] lut_idx,
  output logic [CW-1:0]   lut_chunk,
  input  logic [RW-1:0]   lut_res,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RW-1:0]   out_res,
  output logic            busy,
  output logic            lut_err
);

  state_t          state, state_nxt;
  logic [SW-1:0]   sreg;
  logic [IDXW-1:0] idx;
  logic [RW-1:0]   acc;
  logic [RW-1:0]   sum;
  logic            res_bad;

  mod_add_4051 u_add (
    .a      (acc),
    .b      (lut_res),
    .sum    (sum),
    .ge_mod (res_bad)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    lut_idx   = '0;
    lut_chunk = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        lut_idx   = idx;
        lut_chunk = sreg[CW-1:0];
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // out_res is its own register so it keeps the last residue through IDLE and the next RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      idx     <= '0;
      acc     <= '0;
      out_res <= '0;
      lut_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg <= {{(SW-XW){1'b0}}, in_x};
            idx  <= '0;
            acc  <= '0;
          end
        end
        RUN: begin
          acc  <= sum;
          sreg <= sreg >> CW;
          idx  <= idx + IDXW'(1);
          if (res_bad) lut_err <= 1'b1;
          if (idx == LAST_IDX) out_res <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod4051_seq_reducer.sv
// Self-checking bench: the bench plays the LUT bank and compares residues against a bit-serial
// Horner model of x mod 4051.
module tb_mod4051_seq_reducer;
  import mod4051_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XW-1:0]   in_x;
  logic [IDXW-1:0] lut_idx;
  logic [CW-1:0]   lut_chunk;
  logic [RW-1:0]   lut_res;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_res;
  logic            busy;
  logic            lut_err;

  int checks = 0;
  int errors = 0;
  bit fault_en = 1'b0;
  int fault_idx = 10;

  always #5 clk = ~clk;

  mod4051_seq_reducer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .lut_idx   (lut_idx),
    .lut_chunk (lut_chunk),
    .lut_res   (lut_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .busy      (busy),
    .lut_err   (lut_err)
  );

  // External LUT bank: (chunk * 64^idx) mod 4051, with an optional out-of-range fault.
  function automatic logic [RW-1:0] lut_model(input int i, input int c);
    int p = 1;
    for (int j = 0; j < i; j++) p = (p * 64) % 4051;
    return RW'((c * p) % 4051);
  endfunction

  always_comb begin
    lut_res = '0;
    if (int'(lut_idx) < 84) lut_res = lut_model(int'(lut_idx), int'(lut_chunk));
    if (fault_en && int'(lut_idx) == fault_idx) lut_res = 12'd4051;
  end

  // MSB-first Horner over single bits: independent of the chunked LSB-first walk.
  function automatic logic [RW-1:0] ref_mod(input logic [XW-1:0] x);
    int r = 0;
    for (int i = XW - 1; i >= 0; i--) r = (r * 2 + int'(x[i])) % 4051;
    return RW'(r);
  endfunction

  function automatic logic [XW-1:0] rand_x();
    logic [XW-1:0] x;
    for (int k = 0; k < 15; k++) x[32*k +: 32] = $urandom;
    x[499:480] = 20'($urandom);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [XW-1:0] x, input logic [RW-1:0] exp, input bit chk_res,
                        input int hold, input int rst_at, input string nm);
    logic [SW-1:0] xe;
    int n, bad;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " in_ready"}, in_ready, 1);
    xe = {{(SW-XW){1'b0}}, x};
    if (hold > 0) out_ready = 1'b0;
    in_valid = 1'b1;
    in_x = x;
    @(negedge clk);
    in_valid = 1'b0;
    in_x = rand_x();
    bad = 0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({nm, " rst in_ready"}, in_ready, 1);
        chk({nm, " rst busy"}, busy, 0);
        chk({nm, " rst out_valid"}, out_valid, 0);
        chk({nm, " rst lut_idx"}, lut_idx, 0);
        return;
      end
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
          lut_idx !== IDXW'(i) || lut_chunk !== xe[CW*i +: CW]) bad++;
      @(negedge clk);
    end
    // Sampled after edge T+84: first cycle of DONE (cycle T+85).
    chk({nm, " run_seq_bad_cycles"}, bad, 0);
    chk({nm, " out_valid"}, out_valid, 1);
    chk({nm, " busy_done"}, busy, 0);
    if (chk_res) chk({nm, " out_res"}, out_res, exp);
    if (hold > 0) begin
      bad = 0;
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1;
        in_x = rand_x();
        if (out_valid !== 1'b1 || out_res !== exp || in_ready !== 1'b0 || busy !== 1'b0) bad++;
        @(negedge clk);
      end
      chk({nm, " hold_bad_cycles"}, bad, 0);
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, " post out_valid"}, out_valid, 0);
    chk({nm, " post in_ready"}, in_ready, 1);
    chk({nm, " post busy"}, busy, 0);
    if (chk_res) chk({nm, " post out_res"}, out_res, exp);
  endtask

  typedef struct {
    logic [XW-1:0] x;
    logic [RW-1:0] exp;
  } vec_t;

  vec_t tbl[9];
  logic [XW-1:0] xv;

  initial begin
    tbl[0] = '{500'd0,    12'd0};
    tbl[1] = '{500'd4051, 12'd0};
    tbl[2] = '{500'd4050, 12'd4050};
    tbl[3] = '{500'd4096, 12'd45};
    tbl[4] = '{500'd4052, 12'd1};
    tbl[5] = '{500'd4095, 12'd44};
    tbl[6] = '{500'd8101, 12'd4050};
    xv = '0;
    xv[499] = 1'b1;
    tbl[7] = '{xv, ref_mod(xv)};
    xv = '1;
    tbl[8] = '{xv, ref_mod(xv)};

    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_res", out_res, 0);
    chk("reset busy", busy, 0);
    chk("reset lut_err", lut_err, 0);
    chk("reset lut_idx", lut_idx, 0);
    chk("reset lut_chunk", lut_chunk, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op(tbl[i].x, tbl[i].exp, 1'b1, 0, -1, $sformatf("vec%0d", i));
    chk("lut_err clean", lut_err, 0);

    for (int i = 0; i < 1000; i++) begin
      xv = rand_x();
      run_op(xv, ref_mod(xv), 1'b1, 0, -1, "rand");
    end

    xv = rand_x();
    run_op(xv, ref_mod(xv), 1'b1, 20, -1, "backpressure");

    run_op(rand_x(), 12'd0, 1'b0, 0, 40, "mid_reset");
    run_op(500'd4096, 12'd45, 1'b1, 0, -1, "after_reset");

    fault_en = 1'b1;
    run_op(rand_x(), 12'd0, 1'b0, 0, -1, "fault");
    fault_en = 1'b0;
    chk("lut_err set", lut_err, 1);
    xv = rand_x();
    run_op(xv, ref_mod(xv), 1'b1, 0, -1, "after_fault");
    chk("lut_err sticky", lut_err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lut_err cleared", lut_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
